// File: rtl/i_cache_nway.sv
// N-way set-associative instruction cache with multi-beat line refill,
// fence.i invalidation and fetch-kill handling. Returns one 32-bit word per
// accepted fetch. Tags, valid bits and line data live in internal flop arrays.
module i_cache_nway #(
  parameter int WAYS       = 2,
  parameter int INDEX_W    = 6,
  parameter int LINE_BEATS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        core_kill,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  input  logic        inv_req,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  input  logic        mem_rdata_valid,
  input  logic [63:0] mem_rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int OFF_W  = 3 + $clog2(LINE_BEATS);
  localparam int TAG_W  = 64 - INDEX_W - OFF_W;
  localparam int SETS   = 1 << INDEX_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL_REQ, REFILL_DATA, INVAL} state_t;

  state_t              state;
  logic [63:0]         addr_q;
  logic                kill_pend;
  logic                inv_pend;
  logic                refilled;
  logic [WAY_W-1:0]    victim;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [SETS-1:0]     valid [WAYS];
  logic [WAY_W-1:0]    rr    [SETS];

  logic [63:0]         data_mem [WAYS][SETS][LINE_BEATS];
  logic [TAG_W-1:0]    tag_mem  [WAYS][SETS];

  logic [INDEX_W-1:0]  set_idx;
  logic [TAG_W-1:0]    tag_in;
  logic [BEAT_W-1:0]   beat_sel;
  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic                any_invalid;
  logic [WAY_W-1:0]    free_way;
  logic [63:0]         hit_beat;
  logic                last_beat;
  logic [WAY_W-1:0]    rr_next;
  logic                unused_addr_bits;

  function automatic logic [31:0] pick_word(input logic [63:0] beat, input logic hi);
    return hi ? beat[63:32] : beat[31:0];
  endfunction

  assign set_idx          = addr_q[OFF_W +: INDEX_W];
  assign tag_in           = addr_q[63 -: TAG_W];
  assign unused_addr_bits = ^addr_q[1:0];
  assign req_ready        = (state == IDLE) && !inv_pend;
  assign hit_beat         = data_mem[hit_way][set_idx][beat_sel];
  assign last_beat        = (beat_cnt == BEAT_W'(LINE_BEATS - 1));
  assign rr_next          = (rr[set_idx] == WAY_W'(WAYS - 1)) ? '0 : rr[set_idx] + WAY_W'(1);

  generate
    if (LINE_BEATS > 1) begin : g_beat_sel
      assign beat_sel = addr_q[3 +: BEAT_W];
    end else begin : g_single_beat
      assign beat_sel = '0;
    end
  endgenerate

  // Tag compare across all ways; descending scan makes the lowest way win.
  always_comb begin
    hit         = 1'b0;
    hit_way     = '0;
    any_invalid = 1'b0;
    free_way    = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[w][set_idx] && (tag_mem[w][set_idx] == tag_in)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid[w][set_idx]) begin
        any_invalid = 1'b1;
        free_way    = WAY_W'(w);
      end
    end
  end

  // Fetch address capture on accept (datapath, no reset).
  always_ff @(posedge clk) begin
    if ((state == IDLE) && req_valid && req_ready) begin
      addr_q <= req_addr;
    end
  end

  // Refill write path: one beat per valid cycle, tag written with the last beat.
  always_ff @(posedge clk) begin
    if ((state == REFILL_DATA) && mem_rdata_valid) begin
      data_mem[victim][set_idx][beat_cnt] <= mem_rdata;
      if (last_beat) begin
        tag_mem[victim][set_idx] <= tag_in;
      end
    end
  end

  // Control FSM with registered outputs, counters and valid/round-robin state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      kill_pend     <= 1'b0;
      inv_pend      <= 1'b0;
      refilled      <= 1'b0;
      victim        <= '0;
      beat_cnt      <= '0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
      for (int w = 0; w < WAYS; w++) valid[w] <= '0;
      for (int s = 0; s < SETS; s++) rr[s] <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (inv_req) inv_pend <= 1'b1;
      case (state)
        // IDLE: pending invalidation beats a new fetch
        IDLE: begin
          kill_pend <= 1'b0;
          refilled  <= 1'b0;
          if (inv_pend) begin
            state <= INVAL;
          end else if (req_valid) begin
            state <= LOOKUP;
          end
        end
        // LOOKUP: respond on hit, otherwise choose victim and request the line
        LOOKUP: begin
          if (hit) begin
            resp_valid <= !(kill_pend || core_kill);
            resp_data  <= pick_word(hit_beat, addr_q[2]);
            if (!refilled) hit_cnt <= hit_cnt + 32'd1;
            state <= IDLE;
          end else begin
            victim        <= any_invalid ? free_way : rr[set_idx];
            miss_cnt      <= miss_cnt + 32'd1;
            mem_req_valid <= 1'b1;
            mem_addr      <= {addr_q[63:OFF_W], {OFF_W{1'b0}}};
            kill_pend     <= kill_pend | core_kill;
            beat_cnt      <= '0;
            state         <= REFILL_REQ;
          end
        end
        // REFILL_REQ: hold the line request until the bridge takes it
        REFILL_REQ: begin
          kill_pend <= kill_pend | core_kill;
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= REFILL_DATA;
          end
        end
        // REFILL_DATA: count beats, install the line on the last one
        REFILL_DATA: begin
          kill_pend <= kill_pend | core_kill;
          if (mem_rdata_valid) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
            if (last_beat) begin
              valid[victim][set_idx] <= 1'b1;
              rr[set_idx]            <= rr_next;
              refilled               <= 1'b1;
              state                  <= LOOKUP;
            end
          end
        end
        // INVAL: wipe everything; a fence.i landing now runs again
        INVAL: begin
          for (int w = 0; w < WAYS; w++) valid[w] <= '0;
          for (int s = 0; s < SETS; s++) rr[s] <= '0;
          inv_pend <= inv_req;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i_cache_nway.sv
// Directed bench for i_cache_nway (WAYS=2, INDEX_W=6, LINE_BEATS=2).
module tb_i_cache_nway;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        core_kill;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        inv_req;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_rdata_valid;
  logic [63:0] mem_rdata;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  i_cache_nway #(.WAYS(2), .INDEX_W(6), .LINE_BEATS(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .core_kill(core_kill),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .inv_req(inv_req),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a fetch for one cycle; returns in the LOOKUP cycle.
  task automatic do_req(input logic [63:0] a, input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_addr  = a;
    step();
    req_valid = 1'b0;
    req_addr  = '0;
  endtask

  task automatic hit(input logic [63:0] a, input logic [31:0] word, input string tag);
    do_req(a, tag);
    chk({tag, "_lookup_rv"}, resp_valid, 0);
    step();
    chk({tag, "_rv"}, resp_valid, 1);
    chk({tag, "_data"}, resp_data, word);
    chk({tag, "_no_mreq"}, mem_req_valid, 0);
    chk({tag, "_ready"}, req_ready, 1);
    step();
    chk({tag, "_pulse"}, resp_valid, 0);
  endtask

  // Miss with 0-wait bridge; inject: 0 none, 1 core_kill, 2 inv_req in beat-0 cycle.
  task automatic refill(input logic [63:0] a, input logic [63:0] b0, input logic [63:0] b1,
                        input int inject, input bit exp_resp, input string tag);
    logic [63:0] beat;
    logic [31:0] word;
    do_req(a, tag);
    chk({tag, "_lookup_rv"}, resp_valid, 0);
    step();
    chk({tag, "_mreq"}, mem_req_valid, 1);
    chk({tag, "_maddr"}, mem_addr, {a[63:4], 4'h0});
    step();
    chk({tag, "_mreq_drop"}, mem_req_valid, 0);
    mem_rdata_valid = 1'b1;
    mem_rdata       = b0;
    if (inject == 1) core_kill = 1'b1;
    if (inject == 2) inv_req = 1'b1;
    step();
    core_kill = 1'b0;
    inv_req   = 1'b0;
    mem_rdata = b1;
    step();
    mem_rdata_valid = 1'b0;
    mem_rdata       = '0;
    chk({tag, "_relookup_rv"}, resp_valid, 0);
    step();
    beat = a[3] ? b1 : b0;
    word = a[2] ? beat[63:32] : beat[31:0];
    chk({tag, "_rv"}, resp_valid, exp_resp);
    if (exp_resp) chk({tag, "_data"}, resp_data, word);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; core_kill = 1'b0; inv_req = 1'b0;
    mem_req_ready = 1'b1; mem_rdata_valid = 1'b0; mem_rdata = '0;
    #1 rst = 1'b1;
    step();
    step();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    rst = 1'b0;
    step();

    // Cold miss then a hit on the other beat of the same line
    refill(64'h8000_0004, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 0, 1, "cold");
    chk("cold_resp_val", resp_data, 32'h1111_2222);
    chk("cold_miss_cnt", miss_cnt, 1);
    chk("cold_hit_cnt", hit_cnt, 0);
    hit(64'h8000_0008, 32'h7777_8888, "hit1");
    chk("hit1_hit_cnt", hit_cnt, 1);
    chk("hit1_miss_cnt", miss_cnt, 1);

    // Set 1: A->way0, B->way1, C evicts A (way0), A evicts B (way1), B evicts C
    refill(64'h1000_0010, 64'hA1A1_A1A1_A0A0_A0A0, 64'hA3A3_A3A3_A2A2_A2A2, 0, 1, "fillA");
    refill(64'h2000_0010, 64'hB1B1_B1B1_B0B0_B0B0, 64'hB3B3_B3B3_B2B2_B2B2, 0, 1, "fillB");
    refill(64'h3000_0010, 64'hC1C1_C1C1_C0C0_C0C0, 64'hC3C3_C3C3_C2C2_C2C2, 0, 1, "fillC");
    hit(64'h2000_0014, 32'hB1B1_B1B1, "hitB");
    refill(64'h1000_0010, 64'hD1D1_D1D1_D0D0_D0D0, 64'hD3D3_D3D3_D2D2_D2D2, 0, 1, "refillA");
    hit(64'h3000_0018, 32'hC2C2_C2C2, "hitC");
    refill(64'h2000_0010, 64'hB5B5_B5B5_B4B4_B4B4, 64'hB7B7_B7B7_B6B6_B6B6, 0, 1, "refillB");
    hit(64'h1000_0010, 32'hD0D0_D0D0, "hitA");
    chk("rr_hit_cnt", hit_cnt, 4);
    chk("rr_miss_cnt", miss_cnt, 6);

    // Kill during refill: line installed, no response
    refill(64'h4000_0020, 64'hE1E1_E1E1_E0E0_E0E0, 64'hE3E3_E3E3_E2E2_E2E2, 1, 0, "kill");
    chk("kill_ready", req_ready, 1);
    hit(64'h4000_0020, 32'hE0E0_E0E0, "kill_hit");
    chk("kill_hit_cnt", hit_cnt, 5);
    chk("kill_miss_cnt", miss_cnt, 7);

    // fence.i during refill: refill completes, INVAL follows, line misses again
    refill(64'h5000_0030, 64'hF1F1_F1F1_F0F0_F0F0, 64'hF3F3_F3F3_F2F2_F2F2, 2, 1, "inv");
    chk("inv_ready_pend", req_ready, 0);
    step();
    chk("inv_ready_inval", req_ready, 0);
    step();
    chk("inv_ready_back", req_ready, 1);
    refill(64'h5000_0030, 64'h9191_9191_9090_9090, 64'h9393_9393_9292_9292, 0, 1, "inv_remiss");
    chk("inv_miss_cnt", miss_cnt, 9);
    chk("inv_hit_cnt", hit_cnt, 5);

    // Reset in the middle of a refill
    do_req(64'h7000_0050, "rstmid");
    step();
    step();
    mem_rdata_valid = 1'b1;
    mem_rdata       = 64'h7777_7777_6666_6666;
    #2 rst = 1'b1;
    #1;
    chk("rstmid_req_ready", req_ready, 1);
    chk("rstmid_resp_valid", resp_valid, 0);
    chk("rstmid_resp_data", resp_data, 0);
    chk("rstmid_mem_req_valid", mem_req_valid, 0);
    chk("rstmid_mem_addr", mem_addr, 0);
    chk("rstmid_hit_cnt", hit_cnt, 0);
    chk("rstmid_miss_cnt", miss_cnt, 0);
    step();
    rst = 1'b0;
    mem_rdata_valid = 1'b0;
    mem_rdata = '0;
    step();
    refill(64'h5000_0030, 64'h8181_8181_8080_8080, 64'h8383_8383_8282_8282, 0, 1, "post_rst");
    chk("post_rst_miss_cnt", miss_cnt, 1);
    chk("post_rst_hit_cnt", hit_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
